// File: rtl/cdc_hs_rx.sv
// Receive side of a four-phase req/ack bundled-data crossing. Synchronizes the
// request into dst_clk, captures the word once per request and hands it downstream.
module cdc_hs_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 8
) (
   input  logic              dst_clk,
   input  logic              reset,
   input  logic              async_req,
   input  logic [DATA_W-1:0] async_data,
   output logic              ack,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   // Downstream valid/ready: a word moves on any edge where out_valid & out_ready;
   // once raised, out_valid and out_data hold unchanged until that edge.

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DELIVER = 2'd1,
      ST_ACK     = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
   logic                   req_s;

   state_e            state_q, state_d;
   logic              ack_q, ack_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              busy_q, busy_d;

   // Plain shift chain: nothing may sit between stages.
   always_comb begin
      req_sync_d = {req_sync_q[SYNC_STAGES-2:0], async_req};
   end

   assign req_s = req_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      ack_d       = ack_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         ST_IDLE: begin
            ack_d       = 1'b0;
            out_valid_d = 1'b0;
            // async_data is stable while req_s is high, so it is safe to sample here.
            if (req_s) begin
               out_data_d  = async_data;
               out_valid_d = 1'b1;
               state_d     = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               ack_d       = 1'b1;
               state_d     = ST_ACK;
            end
         end
         ST_ACK: begin
            // An early req drop lands here with req_s low: ack pulses one cycle.
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            ack_d       = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge dst_clk) begin
      if (reset) begin
         req_sync_q  <= '0;
         state_q     <= ST_IDLE;
         ack_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         req_sync_q  <= req_sync_d;
         state_q     <= state_d;
         ack_q       <= ack_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   assign ack       = ack_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

   a_hold_while_stalled : assert property (@(posedge dst_clk) disable iff (reset)
      (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q)));

   a_no_ack_with_valid : assert property (@(posedge dst_clk) disable iff (reset)
      !(ack_q && out_valid_q));

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Directed bench for cdc_hs_rx: a sender task drives the four-phase request,
// a monitor collects accepted words and a scoreboard compares them in order.
module tb_cdc_hs_rx;

   localparam int SYNC_STAGES = 2;
   localparam int DATA_W      = 8;

   logic              clk;
   logic              reset;
   logic              async_req;
   logic [DATA_W-1:0] async_data;
   logic              ack;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   logic              dir_ready;
   logic              rand_mode;
   logic              rand_ready;

   int n_cmp;
   int n_err;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] rcv_q[$];

   cdc_hs_rx #(
      .SYNC_STAGES(SYNC_STAGES),
      .DATA_W     (DATA_W)
   ) dut (
      .dst_clk   (clk),
      .reset     (reset),
      .async_req (async_req),
      .async_data(async_data),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign out_ready = rand_mode ? rand_ready : dir_ready;

   always @(negedge clk) begin
      rand_ready <= 1'($urandom_range(0, 1));
   end

   // Monitor: record every accepted word.
   always @(posedge clk) begin
      if (!reset && out_valid && out_ready) rcv_q.push_back(out_data);
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input string tag, input logic lvl, input int max);
      int n;
      n = 0;
      while (ack !== lvl && n < max) begin
         tick(1);
         n++;
      end
      check_eq(tag, 32'(ack), 32'(lvl));
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < max) begin
         tick(1);
         n++;
      end
      check_eq(tag, 32'(out_valid), 32'd1);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d);
      async_data = d;
      async_req  = 1'b1;
      wait_ack("send_ack_hi", 1'b1, 200);
      async_req = 1'b0;
      wait_ack("send_ack_lo", 1'b0, 50);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int bad;
      logic [DATA_W-1:0] e;
      logic [DATA_W-1:0] r;

      n_cmp      = 0;
      n_err      = 0;
      reset      = 1'b1;
      async_req  = 1'b0;
      async_data = '0;
      dir_ready  = 1'b0;
      rand_mode  = 1'b0;

      tick(3);
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_data", 32'(out_data), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick(2);

      // Basic transfer: req rises just after edge 0.
      async_data = 8'hA5;
      async_req  = 1'b1;
      tick(2);
      check_eq("basic_valid_e2", 32'(out_valid), 32'd0);
      tick(1);
      check_eq("basic_valid_e3", 32'(out_valid), 32'd1);
      check_eq("basic_data_e3", 32'(out_data), 32'hA5);
      check_eq("basic_busy_e3", 32'(busy), 32'd1);
      check_eq("basic_ack_e3", 32'(ack), 32'd0);
      dir_ready = 1'b1;
      tick(1);
      check_eq("basic_ack_e4", 32'(ack), 32'd1);
      check_eq("basic_valid_e4", 32'(out_valid), 32'd0);
      dir_ready = 1'b0;
      async_req = 1'b0;
      tick(2);
      check_eq("basic_ack_fall_e2", 32'(ack), 32'd1);
      tick(1);
      check_eq("basic_ack_fall_e3", 32'(ack), 32'd0);
      check_eq("basic_busy_end", 32'(busy), 32'd0);
      check_eq("basic_data_held", 32'(out_data), 32'hA5);
      check_eq("basic_rcv_cnt", 32'(rcv_q.size()), 32'd1);
      tick(2);

      // Backpressure: 20 stalled cycles.
      async_data = 8'h3C;
      async_req  = 1'b1;
      wait_valid("bp_valid", 20);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (out_valid !== 1'b1 || out_data !== 8'h3C || ack !== 1'b0) bad++;
      end
      check_eq("bp_stable_cycles_bad", 32'(bad), 32'd0);
      dir_ready = 1'b1;
      tick(1);
      check_eq("bp_ack_after_ready", 32'(ack), 32'd1);
      dir_ready = 1'b0;
      async_req = 1'b0;
      wait_ack("bp_ack_lo", 1'b0, 20);
      check_eq("bp_rcv_cnt", 32'(rcv_q.size()), 32'd2);

      // Long req: held 50 cycles after ack with ready asserted throughout.
      base       = rcv_q.size();
      dir_ready  = 1'b1;
      async_data = 8'h77;
      async_req  = 1'b1;
      wait_ack("long_ack_hi", 1'b1, 20);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (ack !== 1'b1) bad++;
      end
      check_eq("long_ack_held_bad", 32'(bad), 32'd0);
      check_eq("long_one_handshake", 32'(rcv_q.size() - base), 32'd1);
      async_req = 1'b0;
      wait_ack("long_ack_lo", 1'b0, 20);
      check_eq("long_no_extra", 32'(rcv_q.size() - base), 32'd1);
      dir_ready = 1'b0;
      rcv_q.delete();

      // Ten back-to-back legal transfers with random ready.
      rand_mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(DATA_W'(i));
         send_word(DATA_W'(i));
      end
      rand_mode = 1'b0;
      tick(2);
      check_eq("b2b_count", 32'(rcv_q.size()), 32'd10);
      while (exp_q.size() > 0 && rcv_q.size() > 0) begin
         e = exp_q.pop_front();
         r = rcv_q.pop_front();
         check_eq("b2b_word", 32'(r), 32'(e));
      end
      exp_q.delete();
      rcv_q.delete();

      // Reset while in DELIVER, request low at release.
      async_data = 8'h99;
      async_req  = 1'b1;
      wait_valid("rst_mid_valid", 20);
      async_req = 1'b0;
      reset     = 1'b1;
      tick(1);
      check_eq("rst_mid_valid_lo", 32'(out_valid), 32'd0);
      check_eq("rst_mid_ack_lo", 32'(ack), 32'd0);
      check_eq("rst_mid_busy_lo", 32'(busy), 32'd0);
      reset     = 1'b0;
      dir_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (out_valid !== 1'b0 || ack !== 1'b0 || busy !== 1'b0) bad++;
      end
      check_eq("rst_mid_quiet_bad", 32'(bad), 32'd0);
      check_eq("rst_mid_rcv_cnt", 32'(rcv_q.size()), 32'd0);
      dir_ready = 1'b0;

      // Protocol violation: req drops while the word waits in DELIVER.
      async_data = 8'hC3;
      async_req  = 1'b1;
      wait_valid("viol_valid", 20);
      async_req = 1'b0;
      tick(5);
      check_eq("viol_still_valid", 32'(out_valid), 32'd1);
      check_eq("viol_data", 32'(out_data), 32'hC3);
      dir_ready = 1'b1;
      tick(1);
      check_eq("viol_ack_pulse", 32'(ack), 32'd1);
      check_eq("viol_valid_lo", 32'(out_valid), 32'd0);
      tick(1);
      check_eq("viol_ack_end", 32'(ack), 32'd0);
      check_eq("viol_busy_end", 32'(busy), 32'd0);
      check_eq("viol_rcv_cnt", 32'(rcv_q.size()), 32'd1);
      send_word(8'h5A);
      tick(2);
      check_eq("viol_next_cnt", 32'(rcv_q.size()), 32'd2);
      if (rcv_q.size() == 2) check_eq("viol_next_word", 32'(rcv_q[1]), 32'h5A);

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cdc_hs_rx.md
Name: cdc_hs_rx

Overview:
- Receive end of a four-phase req/ack handshake that carries a bundled data word across clock domains.
- Lives entirely in the destination domain: synchronizes the async request, captures the bundled data, and presents it downstream on a valid/ready interface.
- Returns a registered ack to the sender.
- Pairs with a source-domain transmitter that raises req with stable data and holds both until it sees ack.

Parameters:
- SYNC_STAGES, 2, flops in the req synchronizer chain; legal range >= 2.
- DATA_W, 8, width of the bundled data word.

Ports:
- dst_clk  input  1  destination-domain clock; only clock in the block.
- reset  input  1  synchronous, active-high reset, sampled on posedge dst_clk.
- async_req  input  1  request from source domain; asynchronous to dst_clk.
- async_data  input  DATA_W  bundled data; stable from before async_req rises until ack is observed by sender.
- ack  output  1  acknowledge to source domain; driven directly from a flop.
- out_valid  output  1  captured word available downstream.
- out_ready  input  1  downstream accepts word when out_valid & out_ready.
- out_data  output  DATA_W  captured word.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (synchronous, posedge dst_clk with reset=1):
  - All sync flops = 0, state = IDLE.
  - ack = 0, out_valid = 0, out_data = 0, busy = 0.
- Synchronizer:
  - async_req passes through SYNC_STAGES flops; req_s is the last stage.
  - No logic between stages.
  - async_data is NOT synchronized; it is sampled only when req_s is high, which the bundling rule makes safe.
- FSM states:
  - IDLE: ack=0, out_valid=0. If req_s=1: out_data <= async_data, out_valid <= 1, go to DELIVER.
  - DELIVER: out_valid=1, out_data held. On out_valid & out_ready: out_valid <= 0, ack <= 1, go to ACK. Without ready, stay indefinitely; ack stays 0.
  - ACK: ack=1. When req_s=0: ack <= 0, go to IDLE. Stay while req_s=1.
- Latency:
  - async_req rise (meeting setup at edge 0) -> req_s high after SYNC_STAGES edges -> out_valid high one edge later, i.e. SYNC_STAGES+1 edges.
  - Handshake in same cycle as valid -> ack high on the next edge.
  - async_req fall -> ack low SYNC_STAGES+1 edges later.
- Single delivery:
  - Exactly one out_valid transaction per req high phase.
  - req_s held high through DELIVER/ACK never re-captures.
  - Capture only occurs in IDLE, which is entered only after req_s=0.
- Back-to-back:
  - New req rise while in ACK (before req_s fell) is a sender protocol violation; no requirement beyond no hang.
  - A legal next req (after sender sees ack low) is accepted from IDLE normally.
- Simultaneous events:
  - req_s falls in DELIVER (protocol violation): word still delivered. Then go to ACK, pulse ack high for one cycle, return to IDLE. Must not deadlock.
- Reset mid-operation:
  - Any state -> IDLE, ack=0, out_valid=0, pending word dropped.
  - If async_req is still high after reset release, the word is re-captured and delivered again. The system resets both ends together.
- out_data:
  - Changes only on capture in IDLE.
  - Holds its value after handshake until the next capture.
- ack and busy are glitch-free flop outputs (busy may be decoded from a one-hot state register).

Test Plan:
- Basic transfer: SYNC_STAGES=2, reset released, async_data=8'hA5, async_req rises at edge 0 -> out_valid=1, out_data=8'hA5 at edge 3. out_ready=1 at edge 3 -> ack=1 at edge 4. Drop async_req -> ack=0 three edges later, busy=0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and out_data=8'h3C stable, ack=0 throughout. Ready at cycle 21 -> ack rises next edge.
- Long req: async_req held high 50 cycles after ack rises -> exactly one out_valid handshake, ack stays 1 until req_s falls.
- Ten back-to-back legal transfers with data 0..9 and random out_ready -> downstream receives 0,1,...,9 in order, no duplicates, no drops.
- Reset in DELIVER with async_req low at reset release -> out_valid=0, ack=0, busy=0 the edge after reset asserts; no further output.
- Protocol violation: async_req falls while in DELIVER -> word delivered once, ack pulses high one cycle, FSM returns to IDLE and a following legal transfer of 8'h5A completes.
